// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : io_responder
//  Brief    : Memory-mapped I/O device for the single-cycle MIPS core.
//             Provides an LED register, a debounced switch port, a countdown
//             timer and a status/interrupt-enable register. Reads are a
//             purely combinational mux; writes land on the rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module io_responder #(
   parameter int LED_WIDTH       = 8,
   parameter int SW_WIDTH        = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMER_WIDTH     = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 IOWriteEn,
   input  logic [3:0]           IOAddr,
   input  logic [31:0]          IOWriteData,
   output logic [31:0]          IOReadData,
   input  logic [SW_WIDTH-1:0]  SW,
   output logic [LED_WIDTH-1:0] LED,
   output logic                 IRQ
);

   localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] REG_LED    = 2'd0;
   localparam logic [1:0] REG_SWITCH = 2'd1;
   localparam logic [1:0] REG_TIMER  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic [LED_WIDTH-1:0]   led_reg;
   logic [SW_WIDTH-1:0]    sw_meta;
   logic [SW_WIDTH-1:0]    sw_sync;
   logic [SW_WIDTH-1:0]    sw_prev;
   logic [SW_WIDTH-1:0]    sw_stable;
   logic [DEB_W-1:0]       deb_cnt;
   logic [TIMER_WIDTH-1:0] count;
   logic                   done;
   logic                   swchg;
   logic [1:0]             ie;
   logic                   irq_reg;

   logic                   wr_led;
   logic                   wr_timer;
   logic                   wr_status;
   logic                   sw_accept;
   logic                   timer_expire;
   logic                   unused_bits;

   // Byte offset bits and upper write-data bits are don't-cares for this device.
   assign unused_bits = &{1'b0, IOAddr[1:0], IOWriteData};

   assign wr_led    = IOWriteEn && (IOAddr[3:2] == REG_LED);
   assign wr_timer  = IOWriteEn && (IOAddr[3:2] == REG_TIMER);
   assign wr_status = IOWriteEn && (IOAddr[3:2] == REG_STATUS);

   // A new switch value is accepted once it has been stable long enough and differs.
   assign sw_accept = (sw_sync != sw_stable) && (sw_sync == sw_prev) && (deb_cnt == DEB_LAST);

   // Expiry only on a genuine 1->0 decrement; a reload in the same cycle overrides it.
   assign timer_expire = !wr_timer && (count == TIMER_WIDTH'(1));

   // LED register write.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         led_reg <= '0;
      end else if (wr_led) begin
         led_reg <= IOWriteData[LED_WIDTH-1:0];
      end
   end

   // Two-flop synchroniser followed by a stability counter on the switch port.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_prev   <= '0;
         sw_stable <= '0;
         deb_cnt   <= '0;
      end else begin
         sw_meta <= SW;
         sw_sync <= sw_meta;
         sw_prev <= sw_sync;
         if ((sw_sync == sw_stable) || (sw_sync != sw_prev)) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            sw_stable <= sw_sync;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // Countdown timer: a load takes priority over the decrement, and it stops at zero.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         count <= '0;
      end else if (wr_timer) begin
         count <= IOWriteData[TIMER_WIDTH-1:0];
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Status flags (set beats write-1-to-clear), interrupt enables and registered IRQ.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         done    <= 1'b0;
         swchg   <= 1'b0;
         ie      <= 2'b00;
         irq_reg <= 1'b0;
      end else begin
         done    <= timer_expire | (done  & ~(wr_status & IOWriteData[0]));
         swchg   <= sw_accept    | (swchg & ~(wr_status & IOWriteData[1]));
         if (wr_status) begin
            ie <= IOWriteData[9:8];
         end
         irq_reg <= |({swchg, done} & ie);
      end
   end

   // Read mux: side-effect free, unused bits zero.
   always_comb begin
      IOReadData = '0;
      case (IOAddr[3:2])
         REG_LED:    IOReadData = 32'(led_reg);
         REG_SWITCH: IOReadData = 32'(sw_stable);
         REG_TIMER:  IOReadData = 32'(count);
         REG_STATUS: IOReadData = {22'd0, ie, 6'd0, swchg, done};
         default:    IOReadData = '0;
      endcase
   end

   assign LED = led_reg;
   assign IRQ = irq_reg;

endmodule
`default_nettype wire
